// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register and instruction-fetch stage with debug-loadable instruction memory.
// Rev 1.0 - initial release.
`default_nettype none

module if_fetch_unit #(
  parameter int                   PC_SIZE    = 32,
  parameter int                   INST_SIZE  = 32,
  parameter int                   IMEM_DEPTH = 256,
  parameter logic [INST_SIZE-1:0] HALT_INSTR = 32'hFFFFFFFF
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_enable,
  input  logic                          i_stall,
  input  logic                          i_flush,
  input  logic [PC_SIZE-1:0]            i_next_pc,
  input  logic                          i_wr_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] i_wr_addr,
  input  logic [INST_SIZE-1:0]          i_wr_data,
  output logic [PC_SIZE-1:0]            o_pc,
  output logic [PC_SIZE-1:0]            o_pc_plus4,
  output logic [INST_SIZE-1:0]          o_instr,
  output logic                          o_valid,
  output logic                          o_halt
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                 state;
  logic [PC_SIZE-1:0]     pc;
  logic [INST_SIZE-1:0]   imem [IMEM_DEPTH];
  logic [AW-1:0]          rd_idx;
  logic [INST_SIZE-1:0]   rd_data;
  logic [PC_SIZE-1:0]     pc_plus4;
  logic                   advance;

  // Byte offset ignored; upper PC bits wrap modulo the memory depth.
  assign rd_idx   = pc[AW+1:2];
  assign rd_data  = imem[rd_idx];
  assign pc_plus4 = pc + PC_STEP;
  assign advance  = i_enable & ~i_stall;
  assign o_pc     = pc;

  // Contents survive reset so the debug unit can restart a loaded program.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      imem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      pc         <= '0;
      o_pc_plus4 <= '0;
      o_instr    <= '0;
      o_valid    <= 1'b0;
      o_halt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            o_pc_plus4 <= pc_plus4;
            if (i_flush) begin
              // Squashed path: a HALT here must not stop the machine.
              pc      <= i_next_pc;
              o_instr <= '0;
              o_valid <= 1'b0;
            end else if (rd_data == HALT_INSTR) begin
              o_instr <= HALT_INSTR;
              o_valid <= 1'b1;
              o_halt  <= 1'b1;
              state   <= HALTED;
            end else begin
              pc      <= i_next_pc;
              o_instr <= rd_data;
              o_valid <= 1'b1;
            end
          end
        end
        HALTED: begin
          o_instr <= '0;
          o_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for if_fetch_unit.
// Rev 1.0 - initial release.
`default_nettype none

module tb_if_fetch_unit;

  localparam logic [31:0] A_I  = 32'h11111111;
  localparam logic [31:0] B_I  = 32'h22222222;
  localparam logic [31:0] C_I  = 32'h33333333;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_enable, i_stall, i_flush;
  logic [31:0] i_next_pc;
  logic        i_wr_en;
  logic [7:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic [31:0] o_pc, o_pc_plus4, o_instr;
  logic        o_valid, o_halt;

  logic        np_sel;
  logic [31:0] np_val;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Stimulus helper: default next PC is sequential, overridable for jumps.
  assign i_next_pc = np_sel ? np_val : o_pc + 32'd4;

  if_fetch_unit dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_enable   (i_enable),
    .i_stall    (i_stall),
    .i_flush    (i_flush),
    .i_next_pc  (i_next_pc),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .o_pc       (o_pc),
    .o_pc_plus4 (o_pc_plus4),
    .o_instr    (o_instr),
    .o_valid    (o_valid),
    .o_halt     (o_halt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic out(input string tag, input logic [31:0] instr, input logic [31:0] p4,
                     input logic valid, input logic halt, input logic [31:0] pc);
    check({tag, ".instr"}, o_instr, instr);
    check({tag, ".pc4"},   o_pc_plus4, p4);
    check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, valid});
    check({tag, ".halt"},  {31'd0, o_halt}, {31'd0, halt});
    check({tag, ".pc"},    o_pc, pc);
  endtask

  task automatic do_reset();
    i_reset = 1'b0; i_start = 1'b0; i_enable = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    np_sel = 1'b0;
    tick();
    i_reset = 1'b1;
  endtask

  task automatic start_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_enable = 1'b1;
  endtask

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_enable = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; np_sel = 1'b0; np_val = '0;
    #2;
    out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    i_reset = 1'b1;

    wr(8'd0, A_I); wr(8'd1, B_I); wr(8'd2, C_I); wr(8'd3, HALT);
    wr(8'd4, 32'h55AA55AA); wr(8'd8, 32'h88888888); wr(8'd16, 32'h40404040);
    wr(8'd17, 32'h44444444); wr(8'd18, 32'hA0A0A018); wr(8'd19, 32'hA0A0A019);
    wr(8'd20, 32'hA0A0A020);

    // IDLE ignores enable
    i_enable = 1'b1;
    tick();
    out("idle", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    i_enable = 1'b0;

    // Sequential run with a stall while B is on the output
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    out("start_nofetch", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    i_enable = 1'b1;
    tick(); out("seqA", A_I, 32'd4, 1'b1, 1'b0, 32'd4);
    tick(); out("seqB", B_I, 32'd8, 1'b1, 1'b0, 32'd8);
    i_stall = 1'b1;
    tick(); out("stall1", B_I, 32'd8, 1'b1, 1'b0, 32'd8);
    tick(); out("stall2", B_I, 32'd8, 1'b1, 1'b0, 32'd8);
    i_stall = 1'b0;
    tick(); out("seqC", C_I, 32'd12, 1'b1, 1'b0, 32'd12);
    tick(); out("seqHALT", HALT, 32'd16, 1'b1, 1'b1, 32'd12);
    tick(); out("halted", 32'h0, 32'd16, 1'b0, 1'b1, 32'd12);
    i_start = 1'b1;
    tick(); out("halted_start", 32'h0, 32'd16, 1'b0, 1'b1, 32'd12);
    i_start = 1'b0;

    // Flush redirect to 0x20; flush ignored while stalled
    do_reset();
    #1;
    out("reset2", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    start_run();
    tick(); out("flA", A_I, 32'd4, 1'b1, 1'b0, 32'd4);
    i_flush = 1'b1; np_sel = 1'b1; np_val = 32'h20; i_stall = 1'b1;
    tick(); out("flush_stalled", A_I, 32'd4, 1'b1, 1'b0, 32'd4);
    i_stall = 1'b0;
    tick(); out("flush", 32'h0, 32'd8, 1'b0, 1'b0, 32'h20);
    i_flush = 1'b0; np_sel = 1'b0;
    tick(); out("after_flush", 32'h88888888, 32'h24, 1'b1, 1'b0, 32'h24);

    // HALT on squashed path is ignored
    do_reset();
    wr(8'd2, HALT);
    start_run();
    tick(); out("hfA", A_I, 32'd4, 1'b1, 1'b0, 32'd4);
    tick(); out("hfB", B_I, 32'd8, 1'b1, 1'b0, 32'd8);
    i_flush = 1'b1; np_sel = 1'b1; np_val = 32'h40;
    tick(); out("halt_flushed", 32'h0, 32'd12, 1'b0, 1'b0, 32'h40);
    i_flush = 1'b0; np_sel = 1'b0;
    tick(); out("still_run", 32'h40404040, 32'h44, 1'b1, 1'b0, 32'h44);

    // Same-cycle write to the word being read: old data is fetched
    i_wr_en = 1'b1; i_wr_addr = 8'd17; i_wr_data = 32'h55555555;
    tick();
    i_wr_en = 1'b0;
    out("read_first", 32'h44444444, 32'h48, 1'b1, 1'b0, 32'h48);

    // Step mode: one fetch per one-cycle enable pulse
    i_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_i;
      logic [31:0] exp_pc;
      exp_i  = (k == 0) ? 32'hA0A0A018 : (k == 1) ? 32'hA0A0A019 : 32'hA0A0A020;
      exp_pc = 32'h4C + 32'(4 * k);
      i_enable = 1'b1;
      tick(); out($sformatf("step%0d", k), exp_i, exp_pc, 1'b1, 1'b0, exp_pc);
      i_enable = 1'b0;
      repeat (3) tick();
      out($sformatf("hold%0d", k), exp_i, exp_pc, 1'b1, 1'b0, exp_pc);
    end

    // Asynchronous reset mid-run at pc=0x10, then restart from 0
    do_reset();
    wr(8'd2, C_I);
    start_run();
    tick(); out("arA", A_I, 32'd4, 1'b1, 1'b0, 32'd4);
    np_sel = 1'b1; np_val = 32'h10;
    tick(); out("arB", B_I, 32'd8, 1'b1, 1'b0, 32'h10);
    np_sel = 1'b0;
    #2 i_reset = 1'b0;
    #1 out("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    i_reset = 1'b1;
    i_enable = 1'b0;
    start_run();
    tick(); out("restartA", A_I, 32'd4, 1'b1, 1'b0, 32'd4);
    tick(); out("restartB", B_I, 32'd8, 1'b1, 1'b0, 32'd8);
    tick(); out("restartC", C_I, 32'd12, 1'b1, 1'b0, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
